// File: rtl/parity_fifo_top.sv
// parity_fifo_top: synchronous first-word-fall-through FIFO with valid/grant
// handshakes on both sides and a parity checker on the read side.
//
// Each stored word is DATA_WIDTH+1 bits. When the build defines
// FIFO_PARITY_CHECK_EN, a head word whose overall XOR differs from EVEN_ODD
// is hidden (pop_valid_o=0). A grant pulse still discards it. When the macro
// is not defined, every stored word is presented as valid.
//
// Hierarchy: parity_fifo_top -> fifo_i (parity_fifo_ctrl) -> my_ram (parity_fifo_ram)

// ---------------------------------------------------------------------------
// Storage array: one synchronous write port and one asynchronous read port.
// The read port is asynchronous so the head word falls through in the cycle
// after it is written.
// ---------------------------------------------------------------------------
module parity_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH:0]   wr_data_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH:0]   rd_data_o
);

  logic [DATA_WIDTH:0] memory [0:FIFO_DEPTH-1];

  // Write the addressed entry on an accepted push.
  // NOTE: the array has no reset. Occupancy tracking alone decides which
  // entries are meaningful, and leaving the array unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      memory[wr_addr_i] <= wr_data_i;
    end
  end

  // Combinational read of the head entry.
  assign rd_data_o = memory[rd_addr_i];

endmodule

// ---------------------------------------------------------------------------
// FIFO control: read/write pointers, occupancy counter and raw status.
// pop_valid_o is the raw "not empty" flag. This block does not check parity.
// ---------------------------------------------------------------------------
module parity_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH:0]   push_data_i,
  input  logic                  push_valid_i,
  output logic                  push_grant_o,
  input  logic                  pop_grant_i,
  output logic [DATA_WIDTH:0]   pop_data_o,
  output logic                  pop_valid_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Depth need not be a power of two, so pointers wrap explicitly at the
  // last index instead of relying on natural binary rollover.
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [PTR_W-1:0] count_read,  count_read_d;
  logic [PTR_W-1:0] count_write, count_write_d;
  logic [CNT_W-1:0] count_fifo,  count_fifo_d;

  logic full;
  logic not_empty;
  logic push_en;
  logic pop_en;

  // Status flags. A full FIFO refuses a push even when a pop happens in the
  // same cycle, so the two operations never depend on each other.
  assign full      = (count_fifo == CNT_FULL);
  assign not_empty = (count_fifo != '0);
  assign push_en   = push_valid_i & ~full;
  assign pop_en    = pop_grant_i & not_empty;

  assign push_grant_o = ~full;
  assign pop_valid_o  = not_empty;

  // Compute the next pointer and occupancy values from the accepted push and pop.
  // NOTE: every combinational output is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    count_read_d  = count_read;
    count_write_d = count_write;
    count_fifo_d  = count_fifo;

    if (push_en) begin
      count_write_d = (count_write == PTR_LAST) ? '0 : count_write + PTR_W'(1);
    end

    if (pop_en) begin
      count_read_d = (count_read == PTR_LAST) ? '0 : count_read + PTR_W'(1);
    end

    unique case ({push_en, pop_en})
      2'b10:   count_fifo_d = count_fifo + CNT_W'(1);
      2'b01:   count_fifo_d = count_fifo - CNT_W'(1);
      default: count_fifo_d = count_fifo;
    endcase
  end

  // Register the pointers and occupancy. An asynchronous reset empties the
  // FIFO and drops any words still stored.
  // NOTE: sequential state is written with non-blocking assignments, so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_read  <= '0;
      count_write <= '0;
      count_fifo  <= '0;
    end else begin
      count_read  <= count_read_d;
      count_write <= count_write_d;
      count_fifo  <= count_fifo_d;
    end
  end

  parity_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (PTR_W)
  ) my_ram (
    .clk       (clk),
    .wr_en_i   (push_en),
    .wr_addr_i (count_write),
    .wr_data_i (push_data_i),
    .rd_addr_i (count_read),
    .rd_data_o (pop_data_o)
  );

endmodule

// ---------------------------------------------------------------------------
// Top level: the FIFO plus the read-side parity qualifier.
// ---------------------------------------------------------------------------
module parity_fifo_top #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned EVEN_ODD   = 0,
  parameter int unsigned PARITY_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH:0]   push_data_i,
  input  logic                  push_valid_i,
  output logic                  push_grant_o,
  input  logic                  pop_grant_i,
  output logic [DATA_WIDTH:0]   pop_data_o,
  output logic                  pop_valid_o
);

  // Reject configurations that cannot work: depth below 2, a parity index
  // outside the word, or a parity sense other than 0/1.
  if (FIFO_DEPTH < 2 || PARITY_BIT > DATA_WIDTH || EVEN_ODD > 1) begin : g_bad_cfg
    $error("parity_fifo_top: unsupported parameter combination");
  end

  logic raw_valid;

  parity_fifo_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) fifo_i (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_data_i  (push_data_i),
    .push_valid_i (push_valid_i),
    .push_grant_o (push_grant_o),
    .pop_grant_i  (pop_grant_i),
    .pop_data_o   (pop_data_o),
    .pop_valid_o  (raw_valid)
  );

`ifdef FIFO_PARITY_CHECK_EN
  localparam int unsigned WORD_W      = DATA_WIDTH + 1;
  localparam logic [WORD_W-1:0] PARITY_MASK = WORD_W'(1) << PARITY_BIT;

  logic parity_expected;
  logic parity_ok;

  // The parity bit must equal the parity sense XOR the other bits. This is
  // the same as requiring the XOR of the whole word to equal EVEN_ODD.
  // Corrupt head words stay hidden but can still be granted away.
  always_comb begin
    parity_expected = 1'(EVEN_ODD) ^ (^(pop_data_o & ~PARITY_MASK));
    parity_ok       = (pop_data_o[PARITY_BIT] == parity_expected);
    pop_valid_o     = raw_valid & parity_ok;
  end
`else
  // No checker in this build: every stored word is presented as valid.
  assign pop_valid_o = raw_valid;
`endif

endmodule

// File: tb/tb_parity_fifo_top.sv
// Testbench for parity_fifo_top (default parameters: 32-bit payload, depth 4,
// even parity, parity bit 0). A directed vector table covers reset, overflow,
// underflow and corrupt-word discard. Hand sequences follow for simultaneous
// push/pop with wrap, rate mismatch and mid-transfer reset. A randomized run
// is checked against a queue-based reference model.
module tb_parity_fifo_top;

  localparam int DW       = 32;
  localparam int DEPTH    = 4;
  localparam int EVEN_ODD = 0;

  logic          clk;
  logic          rst_n;
  logic [DW:0]   push_data_i;
  logic          push_valid_i;
  logic          push_grant_o;
  logic          pop_grant_i;
  logic [DW:0]   pop_data_o;
  logic          pop_valid_o;

  parity_fifo_top dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_data_i  (push_data_i),
    .push_valid_i (push_valid_i),
    .push_grant_o (push_grant_o),
    .pop_grant_i  (pop_grant_i),
    .pop_data_o   (pop_data_o),
    .pop_valid_o  (pop_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an ordered queue of stored words plus pointer positions
  // taken modulo the depth.
  logic [DW:0] model_q[$];
  int          model_rd = 0;
  int          model_wr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A word is deliverable when its whole-word XOR matches the parity sense,
  // or in every case when the checker is not built in.
  function automatic logic good(input logic [DW:0] w);
`ifdef FIFO_PARITY_CHECK_EN
    return ((^w) == 1'(EVEN_ODD));
`else
    return 1'b1;
`endif
  endfunction

  // Build an even-parity word from a running number.
  function automatic logic [DW:0] good_word(input int n);
    logic [DW:0] w;
    w    = (DW+1)'(n) << 1;
    w[0] = ^w;
    return w;
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_rd = 0;
    model_wr = 0;
  endtask

  task automatic model_step(input logic push, input logic [DW:0] d, input logic pop);
    bit push_ok;
    bit pop_ok;
    push_ok = push && (model_q.size() < DEPTH);
    pop_ok  = pop && (model_q.size() > 0);
    if (pop_ok) begin
      void'(model_q.pop_front());
      model_rd = (model_rd + 1) % DEPTH;
    end
    if (push_ok) begin
      model_q.push_back(d);
      model_wr = (model_wr + 1) % DEPTH;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/grant"}, 64'(push_grant_o), 64'(model_q.size() != DEPTH));
    check({tag, "/valid"}, 64'(pop_valid_o),
          64'((model_q.size() > 0) && good(model_q.size() > 0 ? model_q[0] : '0)));
    check({tag, "/count"}, 64'(dut.fifo_i.count_fifo), 64'(model_q.size()));
    check({tag, "/rd"},    64'(dut.fifo_i.count_read),  64'(model_rd));
    check({tag, "/wr"},    64'(dut.fifo_i.count_write), 64'(model_wr));
    if (model_q.size() > 0) begin
      check({tag, "/data"}, 64'(pop_data_o), 64'(model_q[0]));
    end
  endtask

  // Drive one cycle: the caller is at a falling edge. The task returns at the
  // next falling edge, after the checks.
  task automatic cycle(input string tag, input logic push, input logic [DW:0] d, input logic pop);
    push_valid_i = push;
    push_data_i  = d;
    pop_grant_i  = pop;
    @(posedge clk);
    model_step(push, d, pop);
    @(negedge clk);
    compare_all(tag);
  endtask

  typedef struct {
    logic        push;
    logic [DW:0] data;
    logic        pop;
    logic        exp_grant;
    int          exp_count;
    logic [DW:0] exp_head;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic push, input logic [DW:0] data, input logic pop,
                              input logic exp_grant, input int exp_count,
                              input logic [DW:0] exp_head);
    vec_t v;
    v.push = push; v.data = data; v.pop = pop;
    v.exp_grant = exp_grant; v.exp_count = exp_count; v.exp_head = exp_head;
    return v;
  endfunction

  initial begin
    logic [DW:0] rnd;
    int          seq;

    // Overflow: six pushes into a depth-4 FIFO. The last two are dropped.
    vecs.push_back(mk(1, 33'h2, 0, 1, 1, 33'h2));
    vecs.push_back(mk(1, 33'h4, 0, 1, 2, 33'h2));
    vecs.push_back(mk(1, 33'h6, 0, 1, 3, 33'h2));
    vecs.push_back(mk(1, 33'h8, 0, 0, 4, 33'h2));
    vecs.push_back(mk(1, 33'hA, 0, 0, 4, 33'h2));
    vecs.push_back(mk(1, 33'hC, 0, 0, 4, 33'h2));
    // Underflow: six pops. The last ones find the FIFO empty.
    vecs.push_back(mk(0, 33'h0, 1, 1, 3, 33'h4));
    vecs.push_back(mk(0, 33'h0, 1, 1, 2, 33'h6));
    vecs.push_back(mk(0, 33'h0, 1, 1, 1, 33'h8));
    vecs.push_back(mk(0, 33'h0, 1, 1, 0, 33'h0));
    vecs.push_back(mk(0, 33'h0, 1, 1, 0, 33'h0));
    vecs.push_back(mk(0, 33'h0, 1, 1, 0, 33'h0));
    // Corrupt discard: 0x1 has odd parity and 0x3 has even parity.
    vecs.push_back(mk(1, 33'h1, 0, 1, 1, 33'h1));
    vecs.push_back(mk(1, 33'h3, 0, 1, 2, 33'h1));
    vecs.push_back(mk(0, 33'h0, 1, 1, 1, 33'h3));

    push_valid_i = 1'b0;
    push_data_i  = '0;
    pop_grant_i  = 1'b0;
    rst_n        = 1'b0;
    model_reset();

    // Reset held for 10 ns with the clock running.
    #8;
    check("reset/count_fifo",  64'(dut.fifo_i.count_fifo),  64'(0));
    check("reset/count_read",  64'(dut.fifo_i.count_read),  64'(0));
    check("reset/count_write", 64'(dut.fifo_i.count_write), 64'(0));
    check("reset/grant",       64'(push_grant_o), 64'(1));
    check("reset/valid",       64'(pop_valid_o),  64'(0));
    #2;
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      push_valid_i = vecs[i].push;
      push_data_i  = vecs[i].data;
      pop_grant_i  = vecs[i].pop;
      @(posedge clk);
      model_step(vecs[i].push, vecs[i].data, vecs[i].pop);
      @(negedge clk);
      check($sformatf("vec%0d/grant", i), 64'(push_grant_o), 64'(vecs[i].exp_grant));
      check($sformatf("vec%0d/count", i), 64'(dut.fifo_i.count_fifo), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d/valid", i), 64'(pop_valid_o),
            64'((vecs[i].exp_count > 0) && good(vecs[i].exp_head)));
      if (vecs[i].exp_count > 0) begin
        check($sformatf("vec%0d/data", i), 64'(pop_data_o), 64'(vecs[i].exp_head));
      end
      if (i == 5) begin
        for (int m = 0; m < DEPTH; m++) begin
          check($sformatf("mem%0d", m), 64'(dut.fifo_i.my_ram.memory[m]), 64'(2 * (m + 1)));
        end
      end
    end
    compare_all("after_table");

    // Simultaneous push and pop with pointer wrap. First drain the leftover word.
    cycle("drain", 1'b0, '0, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      cycle($sformatf("simul%0d", k), 1'b1, (DW+1)'(3 * k), 1'b1);
    end
    while (model_q.size() > 0) cycle("simul_drain", 1'b0, '0, 1'b1);

    // Rate mismatch: two pushes per pop, then one push per two pops.
    seq = 1;
    for (int k = 0; k < 30; k++) begin
      cycle("fast_in_a", 1'b1, good_word(seq), 1'b0); seq++;
      cycle("fast_in_b", 1'b1, good_word(seq), 1'b1); seq++;
    end
    for (int k = 0; k < 30; k++) begin
      cycle("fast_out_a", 1'b1, good_word(seq), 1'b1); seq++;
      cycle("fast_out_b", 1'b0, '0, 1'b1);
    end

    // Randomized traffic with random parity.
    for (int k = 0; k < 400; k++) begin
      rnd = {1'($urandom), 32'($urandom)};
      cycle("rand", 1'($urandom_range(0, 1)), rnd, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of traffic drops stored words at once.
    cycle("pre_rst_a", 1'b1, good_word(7), 1'b0);
    cycle("pre_rst_b", 1'b1, good_word(8), 1'b0);
    push_valid_i = 1'b0;
    pop_grant_i  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst/count_fifo",  64'(dut.fifo_i.count_fifo),  64'(0));
    check("midrst/count_read",  64'(dut.fifo_i.count_read),  64'(0));
    check("midrst/count_write", 64'(dut.fifo_i.count_write), 64'(0));
    check("midrst/grant",       64'(push_grant_o), 64'(1));
    check("midrst/valid",       64'(pop_valid_o),  64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare_all("post_rst");
    cycle("post_rst_push", 1'b1, good_word(9), 1'b0);
    cycle("post_rst_pop",  1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
